// File: rtl/uart_csr_ctrl.sv
// UART CSR controller: CPU register bus, sticky error flags, Rx FIFO fill and Tx FIFO drain sequencer.
// Optional feature macro UART_CSR_IRQ_EN adds the IRQ_EN CSR at address 4 and the irq_o output.
module uart_csr_ctrl #(
  parameter int MAX_UART_DATA_W = 8,
  parameter int STOP_CONF_W     = 2,
  parameter int DATA_CONF_W     = 2,
  parameter int BAUD_RATE_SEL_W = 2,
  parameter int TOTAL_CONF_W    = STOP_CONF_W + DATA_CONF_W + 1,
  parameter int ADDR_W          = 3,
  parameter int DATA_W          = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [ADDR_W-1:0]          cpu_addr_i,
  input  logic                       cpu_wr_en_i,
  input  logic                       cpu_rd_en_i,
  input  logic [DATA_W-1:0]          cpu_wdata_i,
  output logic [DATA_W-1:0]          cpu_rdata_o,
  output logic                       cpu_rvalid_o,
  output logic                       cpu_err_o,
  output logic                       tx_fifo_push_o,
  output logic [MAX_UART_DATA_W-1:0] tx_fifo_wdata_o,
  output logic                       tx_fifo_pop_o,
  input  logic [MAX_UART_DATA_W-1:0] tx_fifo_rdata_i,
  input  logic                       tx_fifo_full_i,
  input  logic                       tx_fifo_nearly_full_i,
  input  logic                       tx_fifo_empty_i,
  input  logic                       tx_fifo_nearly_empty_i,
  output logic                       rx_fifo_push_o,
  output logic [MAX_UART_DATA_W-1:0] rx_fifo_wdata_o,
  output logic                       rx_fifo_pop_o,
  input  logic [MAX_UART_DATA_W-1:0] rx_fifo_rdata_i,
  input  logic                       rx_fifo_full_i,
  input  logic                       rx_fifo_nearly_full_i,
  input  logic                       rx_fifo_empty_i,
  input  logic                       rx_fifo_nearly_empty_i,
  input  logic                       tx_done_i,
  input  logic                       tx_busy_i,
  input  logic                       rx_done_i,
  input  logic                       rx_busy_i,
  input  logic                       rx_parity_err_i,
  input  logic                       rx_stop_err_i,
  input  logic [MAX_UART_DATA_W-1:0] rx_data_i,
  output logic [BAUD_RATE_SEL_W-1:0] baud_sel_o,
  output logic                       tx_en_o,
  output logic                       rx_en_o,
  output logic [TOTAL_CONF_W-1:0]    tx_conf_o,
  output logic [TOTAL_CONF_W-1:0]    rx_conf_o,
  output logic                       tx_start_o,
  output logic [MAX_UART_DATA_W-1:0] tx_data_o
`ifdef UART_CSR_IRQ_EN
  ,
  output logic                       irq_o
`endif
);

  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TXD  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_RXD  = ADDR_W'(3);

  localparam logic [DATA_W-1:0] CONF_ONES = DATA_W'((64'd1 << TOTAL_CONF_W) - 64'd1);
  localparam logic [DATA_W-1:0] BAUD_ONES = DATA_W'((64'd1 << BAUD_RATE_SEL_W) - 64'd1);
  localparam logic [DATA_W-1:0] CTRL_MASK = DATA_W'(1) | (CONF_ONES << 2) | (DATA_W'(1) << 16)
                                          | (CONF_ONES << 18) | (BAUD_ONES << 30);
  // TX_OVF, PAR_ERR, STOP_ERR, RX_OVF, RX_UFL
  localparam logic [DATA_W-1:0] STICKY_MASK = 32'h003C_0010;

  typedef enum logic [1:0] {S_IDLE, S_POP, S_START, S_WAIT} tx_state_e;

  tx_state_e                  state_q, state_d;
  logic [DATA_W-1:0]          ctrl_q, ctrl_d, sticky_q, sticky_d, sticky_set, rdata_q, rdata_d, stat;
  logic                       rvalid_q, err_q, rx_pop_q, tx_push_q, rx_push_q;
  logic [MAX_UART_DATA_W-1:0] tx_wdata_q, rx_wdata_q, tx_data_q;
  logic                       wr, rd, is_stat, is_ctrl, is_txd, is_rxd, mapped;

`ifdef UART_CSR_IRQ_EN
  localparam logic [ADDR_W-1:0] A_IRQ = ADDR_W'(4);
  logic [DATA_W-1:0] irq_en_q;
  logic              irq_q, is_irq;
  assign is_irq = (cpu_addr_i == A_IRQ);
`endif

  assign wr      = cpu_wr_en_i;
  assign rd      = cpu_rd_en_i & ~cpu_wr_en_i;
  assign is_stat = (cpu_addr_i == A_STAT);
  assign is_ctrl = (cpu_addr_i == A_CTRL);
  assign is_txd  = (cpu_addr_i == A_TXD);
  assign is_rxd  = (cpu_addr_i == A_RXD);
`ifdef UART_CSR_IRQ_EN
  assign mapped  = is_stat | is_ctrl | is_txd | is_rxd | is_irq;
`else
  assign mapped  = is_stat | is_ctrl | is_txd | is_rxd;
`endif

  // STAT view: live core/FIFO status merged over the sticky flags
  always_comb begin
    stat     = sticky_q;
    stat[0]  = tx_done_i;
    stat[1]  = tx_busy_i;
    stat[8]  = tx_fifo_empty_i;
    stat[9]  = tx_fifo_nearly_empty_i;
    stat[10] = tx_fifo_full_i;
    stat[11] = tx_fifo_nearly_full_i;
    stat[16] = rx_done_i;
    stat[17] = rx_busy_i;
    stat[24] = rx_fifo_empty_i;
    stat[25] = rx_fifo_nearly_empty_i;
    stat[26] = rx_fifo_full_i;
    stat[27] = rx_fifo_nearly_full_i;
  end

  always_comb begin
    sticky_set     = '0;
    sticky_set[4]  = wr & is_txd & tx_fifo_full_i;
    sticky_set[18] = rx_done_i & rx_parity_err_i;
    sticky_set[19] = rx_done_i & rx_stop_err_i;
    sticky_set[20] = rx_done_i & ctrl_q[16] & rx_fifo_full_i;
    sticky_set[21] = rd & is_rxd & rx_fifo_empty_i;
    // clear first, then set, so a new event in the W1C cycle survives
    sticky_d = (sticky_q & ~((wr & is_stat) ? (cpu_wdata_i & STICKY_MASK) : '0)) | sticky_set;
    ctrl_d   = (wr & is_ctrl) ? (cpu_wdata_i & CTRL_MASK) : ctrl_q;
    rdata_d  = '0;
    if (rd) begin
      if (is_stat)                          rdata_d = stat;
      else if (is_ctrl)                     rdata_d = ctrl_q;
      else if (is_rxd && !rx_fifo_empty_i)  rdata_d = DATA_W'(rx_fifo_rdata_i);
`ifdef UART_CSR_IRQ_EN
      else if (is_irq)                      rdata_d = irq_en_q;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q     <= '0;
      sticky_q   <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rx_pop_q   <= 1'b0;
      tx_push_q  <= 1'b0;
      rx_push_q  <= 1'b0;
      tx_wdata_q <= '0;
      rx_wdata_q <= '0;
      tx_data_q  <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      sticky_q  <= sticky_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rd;
      err_q     <= (wr | rd) & ~mapped;
      rx_pop_q  <= rd & is_rxd & ~rx_fifo_empty_i;
      tx_push_q <= wr & is_txd & ~tx_fifo_full_i;
      rx_push_q <= rx_done_i & ctrl_q[16] & ~rx_fifo_full_i;
      if (wr & is_txd)      tx_wdata_q <= cpu_wdata_i[MAX_UART_DATA_W-1:0];
      if (rx_done_i)        rx_wdata_q <= rx_data_i;
      if (state_q == S_POP) tx_data_q  <= tx_fifo_rdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // tx_en is only sampled in IDLE, so disabling lets the current char finish
  always_comb begin
    state_d       = state_q;
    tx_fifo_pop_o = 1'b0;
    tx_start_o    = 1'b0;
    case (state_q)
      S_IDLE:  if (ctrl_q[0] && !tx_fifo_empty_i && !tx_busy_i) state_d = S_POP;
      S_POP:   begin tx_fifo_pop_o = 1'b1; state_d = S_START; end
      S_START: begin tx_start_o = 1'b1; state_d = S_WAIT; end
      S_WAIT:  if (tx_done_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef UART_CSR_IRQ_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr & is_irq) irq_en_q <= cpu_wdata_i;
      irq_q <= |(stat & irq_en_q);
    end
  end
  assign irq_o = irq_q;
`endif

  assign cpu_rdata_o     = rdata_q;
  assign cpu_rvalid_o    = rvalid_q;
  assign cpu_err_o       = err_q;
  assign tx_fifo_push_o  = tx_push_q;
  assign tx_fifo_wdata_o = tx_wdata_q;
  assign rx_fifo_push_o  = rx_push_q;
  assign rx_fifo_wdata_o = rx_wdata_q;
  assign rx_fifo_pop_o   = rx_pop_q;
  assign tx_data_o       = tx_data_q;
  assign tx_en_o         = ctrl_q[0];
  assign tx_conf_o       = ctrl_q[TOTAL_CONF_W+1:2];
  assign rx_en_o         = ctrl_q[16];
  assign rx_conf_o       = ctrl_q[TOTAL_CONF_W+17:18];
  assign baud_sel_o      = ctrl_q[30 +: BAUD_RATE_SEL_W];

endmodule

// File: tb/tb_uart_csr_ctrl.sv
// Bench for uart_csr_ctrl: a per-cycle reference model queues the expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_uart_csr_ctrl;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]    addr;
  logic          wr, rd;
  logic [31:0]   wdata, rdata_o;
  logic          rvalid_o, err_o;
  logic          txp_o, txpop_o, rxp_o, rxpop_o, start_o;
  logic [7:0]    txw_o, rxw_o, txd_o, tx_head, rx_head, rx_data;
  logic          txf, txnf, txe, txne, rxf, rxnf, rxe, rxne;
  logic          tx_done, tx_busy, rx_done, rx_busy, perr, serr;
  logic [1:0]    baud_o;
  logic          tx_en_o, rx_en_o;
  logic [CW-1:0] tx_conf_o, rx_conf_o;
`ifdef UART_CSR_IRQ_EN
  logic          irq_o;
`endif

  uart_csr_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_addr_i(addr), .cpu_wr_en_i(wr), .cpu_rd_en_i(rd), .cpu_wdata_i(wdata),
    .cpu_rdata_o(rdata_o), .cpu_rvalid_o(rvalid_o), .cpu_err_o(err_o),
    .tx_fifo_push_o(txp_o), .tx_fifo_wdata_o(txw_o), .tx_fifo_pop_o(txpop_o),
    .tx_fifo_rdata_i(tx_head), .tx_fifo_full_i(txf), .tx_fifo_nearly_full_i(txnf),
    .tx_fifo_empty_i(txe), .tx_fifo_nearly_empty_i(txne),
    .rx_fifo_push_o(rxp_o), .rx_fifo_wdata_o(rxw_o), .rx_fifo_pop_o(rxpop_o),
    .rx_fifo_rdata_i(rx_head), .rx_fifo_full_i(rxf), .rx_fifo_nearly_full_i(rxnf),
    .rx_fifo_empty_i(rxe), .rx_fifo_nearly_empty_i(rxne),
    .tx_done_i(tx_done), .tx_busy_i(tx_busy),
    .rx_done_i(rx_done), .rx_busy_i(rx_busy), .rx_parity_err_i(perr), .rx_stop_err_i(serr),
    .rx_data_i(rx_data),
    .baud_sel_o(baud_o), .tx_en_o(tx_en_o), .rx_en_o(rx_en_o),
    .tx_conf_o(tx_conf_o), .rx_conf_o(rx_conf_o),
    .tx_start_o(start_o), .tx_data_o(txd_o)
`ifdef UART_CSR_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  // pulses: {rvalid, err, tx_push, rx_push, rx_pop, tx_pop, tx_start}
  typedef struct packed {
    logic [6:0]  pulses;
    logic [31:0] rdata;
    logic [7:0]  txw, rxw, txd;
    logic        txd_chk;
    logic [13:0] cfg;
  } rec_t;

  rec_t exp_q[$];
  rec_t pend, cur;
  int   n_chk = 0, n_pass = 0;

  // reference model state
  logic          m_tx_en, m_rx_en, m_txovf, m_par, m_stop, m_rxovf, m_ufl;
  logic [CW-1:0] m_tx_conf, m_rx_conf;
  logic [1:0]    m_baud;
  logic [31:0]   m_irq_en;
  logic [7:0]    m_txchar;
  int            m_phase;   // 0 idle, 1 pop, 2 start, 3 waiting for done

  task automatic model_reset();
    m_tx_en = 0; m_rx_en = 0; m_txovf = 0; m_par = 0; m_stop = 0; m_rxovf = 0; m_ufl = 0;
    m_tx_conf = '0; m_rx_conf = '0; m_baud = '0; m_irq_en = '0; m_txchar = '0; m_phase = 0;
    pend = '0;
  endtask

  function automatic logic [31:0] ctrl_word();
    logic [31:0] w = '0;
    w[0] = m_tx_en; w[2 +: CW] = m_tx_conf; w[16] = m_rx_en; w[18 +: CW] = m_rx_conf;
    w[31:30] = m_baud;
    return w;
  endfunction

  function automatic logic [31:0] stat_word();
    logic [31:0] w = '0;
    w[0] = tx_done; w[1] = tx_busy; w[4] = m_txovf;
    w[8] = txe; w[9] = txne; w[10] = txf; w[11] = txnf;
    w[16] = rx_done; w[17] = rx_busy; w[18] = m_par; w[19] = m_stop; w[20] = m_rxovf; w[21] = m_ufl;
    w[24] = rxe; w[25] = rxne; w[26] = rxf; w[27] = rxnf;
    return w;
  endfunction

  function automatic logic is_mapped(input logic [2:0] a);
`ifdef UART_CSR_IRQ_EN
    return a <= 3'd4;
`else
    return a <= 3'd3;
`endif
  endfunction

  // Predict this cycle's outputs, advance the model across the coming edge.
  task automatic cycle();
    rec_t e, np;
    logic rdv, s_txovf, s_par, s_stop, s_rxovf, s_ufl;
    if (rst) begin
      e = '0;
      e.txd_chk = 1'b1;
      model_reset();
    end else begin
      e = pend;
      e.pulses[1] = (m_phase == 1);
      e.pulses[0] = (m_phase == 2);
      e.cfg       = {m_baud, m_rx_conf, m_rx_en, m_tx_conf, m_tx_en};
      e.txd_chk   = (m_phase >= 2);
      e.txd       = m_txchar;
      rdv = rd && !wr;
      np  = '0;
      s_txovf = 0; s_par = 0; s_stop = 0; s_rxovf = 0; s_ufl = 0;
      if ((wr || rdv) && !is_mapped(addr)) np.pulses[5] = 1'b1;
      if (rdv) begin
        np.pulses[6] = 1'b1;
        case (addr)
          3'd0: np.rdata = stat_word();
          3'd1: np.rdata = ctrl_word();
          3'd3: if (!rxe) begin np.rdata = {24'd0, rx_head}; np.pulses[2] = 1'b1; end
                else s_ufl = 1;
`ifdef UART_CSR_IRQ_EN
          3'd4: np.rdata = m_irq_en;
`endif
          default: np.rdata = '0;
        endcase
      end
      if (wr && addr == 3'd2) begin
        if (txf) s_txovf = 1;
        else begin np.pulses[4] = 1'b1; np.txw = wdata[7:0]; end
      end
      if (rx_done) begin
        if (m_rx_en && !rxf) begin np.pulses[3] = 1'b1; np.rxw = rx_data; end
        if (m_rx_en && rxf) s_rxovf = 1;
        s_par = perr; s_stop = serr;
      end
      if (wr && addr == 3'd0) begin
        if (wdata[4])  m_txovf = 0;
        if (wdata[18]) m_par   = 0;
        if (wdata[19]) m_stop  = 0;
        if (wdata[20]) m_rxovf = 0;
        if (wdata[21]) m_ufl   = 0;
      end
      m_txovf |= s_txovf; m_par |= s_par; m_stop |= s_stop; m_rxovf |= s_rxovf; m_ufl |= s_ufl;
      case (m_phase)
        0:       if (m_tx_en && !txe && !tx_busy) m_phase = 1;
        1:       begin m_txchar = tx_head; m_phase = 2; end
        2:       m_phase = 3;
        default: if (tx_done) m_phase = 0;
      endcase
      if (wr && addr == 3'd1) begin
        m_tx_en = wdata[0]; m_tx_conf = wdata[2 +: CW]; m_rx_en = wdata[16];
        m_rx_conf = wdata[18 +: CW]; m_baud = wdata[31:30];
      end
`ifdef UART_CSR_IRQ_EN
      if (wr && addr == 3'd4) m_irq_en = wdata;
`endif
      pend = np;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      chk("pulses", {25'd0, rvalid_o, err_o, txp_o, rxp_o, rxpop_o, txpop_o, start_o},
          {25'd0, cur.pulses});
      chk("cfg", {18'd0, baud_o, rx_conf_o, rx_en_o, tx_conf_o, tx_en_o}, {18'd0, cur.cfg});
      if (cur.pulses[6]) chk("rdata", rdata_o, cur.rdata);
      if (cur.pulses[4]) chk("tx_wdata", {24'd0, txw_o}, {24'd0, cur.txw});
      if (cur.pulses[3]) chk("rx_wdata", {24'd0, rxw_o}, {24'd0, cur.rxw});
      if (cur.txd_chk)   chk("tx_data", {24'd0, txd_o}, {24'd0, cur.txd});
    end
  end

  task automatic cpu(input logic w, input logic r, input logic [2:0] a, input logic [31:0] d);
    wr = w; rd = r; addr = a; wdata = d;
  endtask

  task automatic env_idle();
    cpu(0, 0, 3'd0, 32'd0);
    txe = 1; txne = 1; txf = 0; txnf = 0; rxe = 1; rxne = 1; rxf = 0; rxnf = 0;
    tx_done = 0; tx_busy = 0; rx_done = 0; rx_busy = 0; perr = 0; serr = 0;
    tx_head = '0; rx_head = '0; rx_data = '0;
  endtask

  task automatic rand_in();
    int op = $urandom_range(0, 7);
    wr    = (op <= 1) || (op == 4);
    rd    = (op == 2) || (op == 3) || (op == 4);
    addr  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
    wdata = $urandom();
    txe = ($urandom_range(0, 4) < 2); txne = $urandom_range(0, 1) == 1;
    txf = ($urandom_range(0, 3) == 0); txnf = $urandom_range(0, 1) == 1;
    rxe = ($urandom_range(0, 4) < 2); rxne = $urandom_range(0, 1) == 1;
    rxf = ($urandom_range(0, 3) == 0); rxnf = $urandom_range(0, 1) == 1;
    tx_busy = ($urandom_range(0, 4) == 0); tx_done = ($urandom_range(0, 3) == 0);
    rx_done = ($urandom_range(0, 3) == 0); rx_busy = $urandom_range(0, 1) == 1;
    perr = ($urandom_range(0, 6) == 0); serr = ($urandom_range(0, 6) == 0);
    tx_head = 8'($urandom()); rx_head = 8'($urandom()); rx_data = 8'($urandom());
  endtask

  initial begin
    env_idle();
    model_reset();
    @(posedge clk); #1;
    cycle(); cycle();
    rst = 0;
    cycle();
    // CTRL write and readback
    cpu(1, 0, 3'd1, 32'hC005_0001); cycle(); cpu(0, 0, 3'd0, 0); cycle();
    cpu(0, 1, 3'd1, 0); cycle(); cpu(0, 0, 3'd0, 0); cycle();
    // TXDATA push, then one character through the sequencer
    cpu(1, 0, 3'd2, 32'h41); cycle(); cpu(0, 0, 3'd0, 0);
    txe = 0; tx_head = 8'h41; cycle(); cycle();
    txe = 1; cycle();
    repeat (4) cycle();
    tx_done = 1; cycle(); tx_done = 0; cycle();
    // receive and read back
    rx_done = 1; rx_data = 8'h5A; cycle(); rx_done = 0;
    rxe = 0; rx_head = 8'h5A; cpu(0, 1, 3'd3, 0); cycle(); cpu(0, 0, 3'd0, 0); cycle(); rxe = 1;
    // Rx overflow, W1C, and W1C colliding with a new overflow
    rxf = 1; rx_done = 1; rx_data = 8'h33; cycle(); rx_done = 0;
    cpu(0, 1, 3'd0, 0); cycle();
    cpu(1, 0, 3'd0, 32'h0010_0000); cycle();
    cpu(0, 1, 3'd0, 0); cycle();
    cpu(1, 0, 3'd0, 32'h0010_0000); rx_done = 1; cycle(); rx_done = 0;
    cpu(0, 1, 3'd0, 0); cycle(); rxf = 0;
    // underflow and unmapped accesses
    cpu(0, 1, 3'd3, 0); cycle(); cpu(0, 1, 3'd0, 0); cycle();
    cpu(0, 1, 3'd5, 0); cycle(); cpu(1, 0, 3'd5, 32'hFFFF_FFFF); cycle();
    cpu(0, 0, 3'd0, 0); cycle();
    // randomized traffic with one reset landing mid-character
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        for (int k = 0; k < 300 && m_phase == 0; k++) begin rand_in(); cycle(); end
        env_idle(); rst = 1; cycle(); cycle(); rst = 0;
        cpu(1, 0, 3'd1, 32'h0001_0001); cycle();
      end
      rand_in();
      cycle();
    end
    env_idle();
    cycle(); cycle();
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
